// File: rtl/enemy_spawn_sched.sv
// Enemy spawn scheduler: paces spawns into a fixed pool of sprite slots, tracks live slots,
// counts kills and raises difficulty by shortening the spawn period.
`ifndef GAME_STATUS_BIT_LEN
`define GAME_STATUS_BIT_LEN 3
`endif

module enemy_spawn_sched #(
    parameter int unsigned SLOTS           = 4,
    parameter int unsigned SPAWN_PERIOD    = 64,
    parameter int unsigned PERIOD_STEP     = 8,
    parameter int unsigned PERIOD_MIN      = 16,
    parameter int unsigned KILLS_PER_LEVEL = 16,
    parameter int unsigned X_MAX           = 600,
    parameter logic [9:0]  LFSR_SEED       = 10'h1A5,
    localparam int unsigned SLOT_W         = $clog2(SLOTS)
) (
    input  logic                            clk_vga,
    input  logic                            rst,
    input  logic [`GAME_STATUS_BIT_LEN-1:0] game_status_i,
    input  logic                            frame_tick_i,
    input  logic                            kill_valid_i,
    input  logic [SLOT_W-1:0]               kill_slot_i,
    input  logic [SLOTS-1:0]                offscreen_i,
    output logic                            spawn_valid_o,
    output logic [SLOT_W-1:0]               spawn_slot_o,
    output logic [9:0]                      spawn_x_o,
    input  logic                            spawn_ready_i,
    output logic [SLOTS-1:0]                slot_active_o,
    output logic [15:0]                     kill_count_o,
    output logic [3:0]                      level_o
);

    typedef enum logic [`GAME_STATUS_BIT_LEN-1:0] {
        GsPause  = `GAME_STATUS_BIT_LEN'(0),
        GsRun    = `GAME_STATUS_BIT_LEN'(1),
        GsPrerun = `GAME_STATUS_BIT_LEN'(2),
        GsOver   = `GAME_STATUS_BIT_LEN'(3)
    } game_status_e;

    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic [7:0]        period_q, period_d;
    logic [9:0]        lfsr_q, lfsr_d;
    logic              spawn_valid_q, spawn_valid_d;
    logic [SLOT_W-1:0] spawn_slot_q, spawn_slot_d;
    logic [9:0]        spawn_x_q, spawn_x_d;
    logic [SLOTS-1:0]  slot_active_q, slot_active_d;
    logic [15:0]       kill_count_q, kill_count_d;
    logic [15:0]       lvl_kills_q, lvl_kills_d;
    logic [3:0]        level_q, level_d;

    game_status_e      status;
    logic              is_run;
    logic              is_live;
    logic              free_found;
    logic [SLOT_W-1:0] free_slot;
    logic [SLOTS-1:0]  kill_mask;
    logic [SLOTS-1:0]  clr_mask;
    logic              kill_hit;
    logic              handshake;
    logic              attempt;
    logic [9:0]        x_fold;

    assign status  = game_status_e'(game_status_i);
    assign is_run  = (status == GsRun);
    assign is_live = (status == GsRun) || (status == GsPause);

    // Lowest-index free slot: scanning downward lets the lowest match win.
    always_comb begin
        free_found = 1'b0;
        free_slot  = '0;
        for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
            if (!slot_active_q[i]) begin
                free_found = 1'b1;
                free_slot  = SLOT_W'(i);
            end
        end
    end

    assign kill_mask = kill_valid_i ? (SLOTS'(1) << kill_slot_i) : '0;
    assign kill_hit  = |(kill_mask & slot_active_q);
    assign clr_mask  = (kill_mask | offscreen_i) & slot_active_q;
    assign handshake = spawn_valid_q && spawn_ready_i;
    assign x_fold    = (lfsr_q >= 10'(X_MAX)) ? (lfsr_q - 10'(X_MAX)) : lfsr_q;

    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        period_d      = period_q;
        lfsr_d        = lfsr_q;
        spawn_valid_d = spawn_valid_q;
        spawn_slot_d  = spawn_slot_q;
        spawn_x_d     = spawn_x_q;
        slot_active_d = slot_active_q;
        kill_count_d  = kill_count_q;
        lvl_kills_d   = lvl_kills_q;
        level_d       = level_q;
        attempt       = 1'b0;

        if (status != GsPrerun) begin
            lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
        end

        if (status == GsPrerun) begin
            frame_cnt_d   = '0;
            period_d      = 8'(SPAWN_PERIOD);
            spawn_valid_d = 1'b0;
            slot_active_d = '0;
            kill_count_d  = '0;
            lvl_kills_d   = '0;
            level_d       = '0;
        end else if (is_live) begin
            if (is_run && frame_tick_i) begin
                // >= so a period shortened below the running count wraps on the next tick
                if (frame_cnt_q >= period_q - 8'd1) begin
                    frame_cnt_d = '0;
                    attempt     = 1'b1;
                end else begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end

            if (attempt && !spawn_valid_q && free_found) begin
                spawn_valid_d = 1'b1;
                spawn_slot_d  = free_slot;
                spawn_x_d     = x_fold;
            end

            if (handshake) begin
                spawn_valid_d = 1'b0;
                slot_active_d = slot_active_q | (SLOTS'(1) << spawn_slot_q);
            end
            slot_active_d = slot_active_d & ~clr_mask;

            if (kill_hit && kill_count_q != 16'hFFFF) begin
                kill_count_d = kill_count_q + 16'd1;
                if (lvl_kills_q == 16'(KILLS_PER_LEVEL - 1)) begin
                    lvl_kills_d = '0;
                    if (level_q != 4'hF) begin
                        level_d = level_q + 4'd1;
                    end
                    if (32'(period_q) >= PERIOD_MIN + PERIOD_STEP) begin
                        period_d = period_q - 8'(PERIOD_STEP);
                    end else begin
                        period_d = 8'(PERIOD_MIN);
                    end
                end else begin
                    lvl_kills_d = lvl_kills_q + 16'd1;
                end
            end
        end else begin
            // OVER and undefined encodings: freeze everything, discard any pending spawn
            spawn_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            frame_cnt_q   <= '0;
            period_q      <= 8'(SPAWN_PERIOD);
            lfsr_q        <= LFSR_SEED;
            spawn_valid_q <= 1'b0;
            spawn_slot_q  <= '0;
            spawn_x_q     <= '0;
            slot_active_q <= '0;
            kill_count_q  <= '0;
            lvl_kills_q   <= '0;
            level_q       <= '0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            period_q      <= period_d;
            lfsr_q        <= lfsr_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_slot_q  <= spawn_slot_d;
            spawn_x_q     <= spawn_x_d;
            slot_active_q <= slot_active_d;
            kill_count_q  <= kill_count_d;
            lvl_kills_q   <= lvl_kills_d;
            level_q       <= level_d;
        end
    end

    assign spawn_valid_o = spawn_valid_q;
    assign spawn_slot_o  = spawn_slot_q;
    assign spawn_x_o     = spawn_x_q;
    assign slot_active_o = slot_active_q;
    assign kill_count_o  = kill_count_q;
    assign level_o       = level_q;

endmodule

// File: tb/tb_enemy_spawn_sched.sv
// Directed self-checking bench for enemy_spawn_sched with default parameters.
module tb_enemy_spawn_sched;

    logic       clk_vga = 1'b0;
    logic       rst;
    logic [2:0] game_status_i;
    logic       frame_tick_i;
    logic       kill_valid_i;
    logic [1:0] kill_slot_i;
    logic [3:0] offscreen_i;
    logic       spawn_valid_o;
    logic [1:0] spawn_slot_o;
    logic [9:0] spawn_x_o;
    logic       spawn_ready_i;
    logic [3:0] slot_active_o;
    logic [15:0] kill_count_o;
    logic [3:0] level_o;

    localparam logic [2:0] PAUSE = 3'b000, RUN = 3'b001, PRERUN = 3'b010, OVER = 3'b011;

    int n_checks = 0;
    int n_pass   = 0;

    enemy_spawn_sched dut (
        .clk_vga       (clk_vga),
        .rst           (rst),
        .game_status_i (game_status_i),
        .frame_tick_i  (frame_tick_i),
        .kill_valid_i  (kill_valid_i),
        .kill_slot_i   (kill_slot_i),
        .offscreen_i   (offscreen_i),
        .spawn_valid_o (spawn_valid_o),
        .spawn_slot_o  (spawn_slot_o),
        .spawn_x_o     (spawn_x_o),
        .spawn_ready_i (spawn_ready_i),
        .slot_active_o (slot_active_o),
        .kill_count_o  (kill_count_o),
        .level_o       (level_o)
    );

    always #5 clk_vga = ~clk_vga;

    // Reference LFSR (x^10 + x^7 + 1), holds in PRERUN; m_prev is the value before the last edge.
    logic [9:0] m_lfsr, m_prev;
    always @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            m_lfsr <= 10'h1A5;
            m_prev <= 10'h1A5;
        end else begin
            m_prev <= m_lfsr;
            if (game_status_i != PRERUN) m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_vga);
        #1;
    endtask

    task automatic run_until_valid(input int max_ticks, output int n);
        n = 0;
        frame_tick_i = 1'b1;
        while (n < max_ticks && !spawn_valid_o) begin
            step();
            n++;
        end
        frame_tick_i = 1'b0;
    endtask

    task automatic kill(input logic [1:0] s);
        kill_valid_i = 1'b1;
        kill_slot_i  = s;
        step();
        kill_valid_i = 1'b0;
    endtask

    initial begin
        int n;
        int exp_n;
        int lvl;
        logic ok;
        logic seen;
        logic [1:0] s0;
        logic [9:0] x0;
        logic [9:0] xe;

        rst = 1'b1;
        game_status_i = PRERUN;
        frame_tick_i = 1'b0;
        kill_valid_i = 1'b0;
        kill_slot_i = '0;
        offscreen_i = '0;
        spawn_ready_i = 1'b0;
        #2;
        check("rst_valid", 32'(spawn_valid_o), 0);
        check("rst_active", 32'(slot_active_o), 0);
        check("rst_kills", 32'(kill_count_o), 0);
        check("rst_level", 32'(level_o), 0);
        check("rst_x", 32'(spawn_x_o), 0);
        step();
        rst = 1'b0;
        step();
        step();

        // First spawn after 64 ticks, ready tied high
        game_status_i = RUN;
        spawn_ready_i = 1'b1;
        run_until_valid(200, n);
        xe = (m_prev >= 10'd600) ? m_prev - 10'd600 : m_prev;
        check("first_ticks", 32'(n), 64);
        check("first_slot", 32'(spawn_slot_o), 0);
        check("first_x_range", 32'(spawn_x_o < 10'd600), 1);
        check("first_x_lfsr", 32'(spawn_x_o), 32'(xe));
        step();
        check("hs1_valid", 32'(spawn_valid_o), 0);
        check("hs1_active", 32'(slot_active_o), 4'b0001);

        // Back-pressure across a second attempt
        spawn_ready_i = 1'b0;
        run_until_valid(200, n);
        check("bp_ticks", 32'(n), 64);
        check("bp_slot", 32'(spawn_slot_o), 1);
        s0 = spawn_slot_o;
        x0 = spawn_x_o;
        ok = 1'b1;
        frame_tick_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            step();
            if (!spawn_valid_o || spawn_slot_o != s0 || spawn_x_o != x0) ok = 1'b0;
        end
        frame_tick_i = 1'b0;
        check("bp_stable", 32'(ok), 1);
        spawn_ready_i = 1'b1;
        step();
        check("bp_hs_valid", 32'(spawn_valid_o), 0);
        check("bp_hs_active", 32'(slot_active_o), 4'b0011);
        step();
        check("bp_one_slot", 32'(slot_active_o), 4'b0011);

        // Fill the pool, then starve
        run_until_valid(200, n);
        check("fill2_slot", 32'(spawn_slot_o), 2);
        step();
        run_until_valid(200, n);
        check("fill3_slot", 32'(spawn_slot_o), 3);
        step();
        check("full_active", 32'(slot_active_o), 4'b1111);
        seen = 1'b0;
        frame_tick_i = 1'b1;
        for (int i = 0; i < 128; i++) begin
            step();
            seen |= spawn_valid_o;
        end
        frame_tick_i = 1'b0;
        check("full_no_spawn", 32'(seen), 0);
        kill(2'd2);
        check("kill2_active", 32'(slot_active_o), 4'b1011);
        check("kill2_count", 32'(kill_count_o), 1);
        run_until_valid(200, n);
        check("refill_ticks", 32'(n), 64);
        check("refill_slot", 32'(spawn_slot_o), 2);
        step();
        check("refill_active", 32'(slot_active_o), 4'b1111);

        // Kill and offscreen on the same slot; kill on an inactive slot; offscreen only
        offscreen_i = 4'b0010;
        kill(2'd1);
        offscreen_i = '0;
        check("dual_active", 32'(slot_active_o), 4'b1101);
        check("dual_count", 32'(kill_count_o), 2);
        kill(2'd1);
        check("inact_count", 32'(kill_count_o), 2);
        offscreen_i = 4'b1000;
        step();
        offscreen_i = '0;
        check("offs_active", 32'(slot_active_o), 4'b0101);
        check("offs_count", 32'(kill_count_o), 2);

        // Level-ups: kill slot 0 and let it refill, 110 times
        for (int k = 3; k <= 112; k++) begin
            if (k == 16) begin
                seen = 1'b0;
                frame_tick_i = 1'b1;
                for (int i = 0; i < 60; i++) begin
                    step();
                    seen |= spawn_valid_o;
                end
                frame_tick_i = 1'b0;
                check("pretick_no_spawn", 32'(seen), 0);
            end
            kill(2'd0);
            run_until_valid(300, n);
            lvl = k / 16;
            exp_n = (64 - 8 * lvl > 16) ? 64 - 8 * lvl : 16;
            if (k == 16) exp_n = 1;
            if (k == 16 || k == 17 || k % 16 == 0) begin
                check($sformatf("interval_k%0d", k), 32'(n), 32'(exp_n));
                check($sformatf("level_k%0d", k), 32'(level_o), 32'(lvl));
                check($sformatf("lvl_slot_k%0d", k), 32'(spawn_slot_o), 0);
            end
            step();
        end
        check("kills_112", 32'(kill_count_o), 112);
        check("active_after_lvl", 32'(slot_active_o), 4'b0101);

        // PAUSE holds a pending spawn, still takes kills and handshakes
        spawn_ready_i = 1'b0;
        run_until_valid(100, n);
        check("p_ticks", 32'(n), 16);
        check("p_slot", 32'(spawn_slot_o), 1);
        s0 = spawn_slot_o;
        x0 = spawn_x_o;
        game_status_i = PAUSE;
        ok = 1'b1;
        frame_tick_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!spawn_valid_o || spawn_slot_o != s0 || spawn_x_o != x0) ok = 1'b0;
        end
        frame_tick_i = 1'b0;
        check("p_stable", 32'(ok), 1);
        kill(2'd0);
        check("p_kill_active", 32'(slot_active_o), 4'b0100);
        check("p_kill_count", 32'(kill_count_o), 113);
        spawn_ready_i = 1'b1;
        step();
        check("p_hs_valid", 32'(spawn_valid_o), 0);
        check("p_hs_active", 32'(slot_active_o), 4'b0110);

        // Counter was frozen during PAUSE; then OVER discards the pending spawn
        spawn_ready_i = 1'b0;
        game_status_i = RUN;
        run_until_valid(100, n);
        check("resume_ticks", 32'(n), 16);
        check("resume_slot", 32'(spawn_slot_o), 0);
        game_status_i = OVER;
        step();
        check("over_valid", 32'(spawn_valid_o), 0);
        spawn_ready_i = 1'b1;
        step();
        check("over_no_hs", 32'(slot_active_o), 4'b0110);
        kill(2'd1);
        offscreen_i = 4'b0100;
        step();
        offscreen_i = '0;
        check("over_kill_count", 32'(kill_count_o), 113);
        check("over_active", 32'(slot_active_o), 4'b0110);
        check("over_level", 32'(level_o), 7);

        // Asynchronous reset with a spawn pending
        spawn_ready_i = 1'b0;
        game_status_i = RUN;
        run_until_valid(100, n);
        check("pre_rst_valid", 32'(spawn_valid_o), 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(spawn_valid_o), 0);
        check("arst_active", 32'(slot_active_o), 0);
        check("arst_kills", 32'(kill_count_o), 0);
        check("arst_level", 32'(level_o), 0);
        check("arst_slot", 32'(spawn_slot_o), 0);
        check("arst_x", 32'(spawn_x_o), 0);
        step();
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
